// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: per-entry record and datapath widths.
package reorder_buffer_pkg;

  localparam int unsigned ROB_XLEN = 32;
  localparam int unsigned REG_W    = 5;

  // One ROB slot; value holds the result, or the resolved next PC for branches.
  typedef struct packed {
    logic                busy;
    logic                ready;
    logic                is_branch;
    logic                mispredicted;
    logic                writes_reg;
    logic [REG_W-1:0]    dest_reg;
    logic [ROB_XLEN-1:0] value;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / lookup / commit bundle of the reorder buffer.
// master: dispatch + CDB + operand lookup side; slave: the reorder buffer.
interface reorder_buffer_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 3
);
  // dispatch
  logic                 alloc_en;
  logic [4:0]           alloc_dest_reg;
  logic                 alloc_writes_reg;
  logic                 alloc_is_branch;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 full;
  logic                 empty;
  // common data bus
  logic                 cdb_valid;
  logic [TAG_WIDTH-1:0] cdb_rob_tag;
  logic [XLEN-1:0]      cdb_data;
  logic                 cdb_mispredicted;
  // operand lookup
  logic [TAG_WIDTH-1:0] lookup_tag_1;
  logic [TAG_WIDTH-1:0] lookup_tag_2;
  logic                 lookup_ready_1;
  logic                 lookup_ready_2;
  logic [XLEN-1:0]      lookup_value_1;
  logic [XLEN-1:0]      lookup_value_2;
  // retire
  logic                 commit_valid;
  logic [4:0]           commit_dest_reg;
  logic [XLEN-1:0]      commit_value;
  logic                 commit_writes_reg;
  logic                 flush;
  logic [XLEN-1:0]      redirect_pc;

  modport master (
    output alloc_en, alloc_dest_reg, alloc_writes_reg, alloc_is_branch,
    output cdb_valid, cdb_rob_tag, cdb_data, cdb_mispredicted,
    output lookup_tag_1, lookup_tag_2,
    input  alloc_tag, full, empty,
    input  lookup_ready_1, lookup_ready_2, lookup_value_1, lookup_value_2,
    input  commit_valid, commit_dest_reg, commit_value, commit_writes_reg,
    input  flush, redirect_pc
  );

  modport slave (
    input  alloc_en, alloc_dest_reg, alloc_writes_reg, alloc_is_branch,
    input  cdb_valid, cdb_rob_tag, cdb_data, cdb_mispredicted,
    input  lookup_tag_1, lookup_tag_2,
    output alloc_tag, full, empty,
    output lookup_ready_1, lookup_ready_2, lookup_value_1, lookup_value_2,
    output commit_valid, commit_dest_reg, commit_value, commit_writes_reg,
    output flush, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at dispatch, captures CDB
// results, retires one entry per cycle in program order and flushes on a
// mispredicted branch reaching the head.
// Ports: clk, reset (async, active-high), bus (reorder_buffer_if.slave).
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned XLEN      = ROB_XLEN,
  parameter int unsigned ROB_SIZE  = 8,
  parameter int unsigned TAG_WIDTH = $clog2(ROB_SIZE)
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave bus
);

  // Extra MSB on each pointer is the wrap bit distinguishing full from empty.
  localparam int unsigned PTR_W = TAG_WIDTH + 1;

  rob_entry             entries_q [ROB_SIZE];
  rob_entry             entries_d [ROB_SIZE];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [TAG_WIDTH-1:0] head_idx, tail_idx;
  logic                 full_c, empty_c, commit_c, flush_c;
  rob_entry             head_e, cdb_e;

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];
  assign head_e   = entries_q[head_idx];
  assign cdb_e    = entries_q[bus.cdb_rob_tag];

  assign empty_c  = (head_q == tail_q);
  assign full_c   = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
  assign commit_c = head_e.busy && head_e.ready;
  assign flush_c  = commit_c && head_e.mispredicted;

  // Next-state: flush overrides everything; otherwise commit, writeback, allocate.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush_c) begin
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        entries_d[i].busy         = 1'b0;
        entries_d[i].ready        = 1'b0;
        entries_d[i].mispredicted = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      if (commit_c) begin
        entries_d[head_idx].busy  = 1'b0;
        entries_d[head_idx].ready = 1'b0;
        head_d = head_q + PTR_W'(1);
      end
      // Late or duplicate broadcasts (entry idle or already ready) are dropped.
      if (bus.cdb_valid && cdb_e.busy && !cdb_e.ready) begin
        entries_d[bus.cdb_rob_tag].ready        = 1'b1;
        entries_d[bus.cdb_rob_tag].value        = ROB_XLEN'(bus.cdb_data);
        entries_d[bus.cdb_rob_tag].mispredicted = bus.cdb_mispredicted && cdb_e.is_branch;
      end
      // Full is evaluated on registered pointers: a slot freed this cycle is
      // only reusable next cycle.
      if (bus.alloc_en && !full_c) begin
        entries_d[tail_idx].busy         = 1'b1;
        entries_d[tail_idx].ready        = 1'b0;
        entries_d[tail_idx].is_branch    = bus.alloc_is_branch;
        entries_d[tail_idx].mispredicted = 1'b0;
        entries_d[tail_idx].writes_reg   = bus.alloc_writes_reg;
        entries_d[tail_idx].dest_reg     = bus.alloc_dest_reg;
        tail_d = tail_q + PTR_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        entries_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Outputs are combinational views of registered state.
  assign bus.alloc_tag         = tail_idx;
  assign bus.full              = full_c;
  assign bus.empty             = empty_c;
  assign bus.commit_valid      = commit_c;
  assign bus.commit_dest_reg   = head_e.dest_reg;
  assign bus.commit_value      = XLEN'(head_e.value);
  assign bus.commit_writes_reg = commit_c && head_e.writes_reg;
  assign bus.flush             = flush_c;
  assign bus.redirect_pc       = XLEN'(head_e.value);

  // Operand lookup: no CDB bypass, stored state only.
  assign bus.lookup_ready_1 = entries_q[bus.lookup_tag_1].busy && entries_q[bus.lookup_tag_1].ready;
  assign bus.lookup_ready_2 = entries_q[bus.lookup_tag_2].busy && entries_q[bus.lookup_tag_2].ready;
  assign bus.lookup_value_1 = XLEN'(entries_q[bus.lookup_tag_1].value);
  assign bus.lookup_value_2 = XLEN'(entries_q[bus.lookup_tag_2].value);

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: program-order queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer;

  localparam int ROBN = 8;

  logic clk;
  logic reset;

  reorder_buffer_if #(.XLEN(32), .TAG_WIDTH(3)) bus ();

  reorder_buffer #(.XLEN(32), .ROB_SIZE(8), .TAG_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: in-flight instructions in program order ----------
  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          wr;
    bit          br;
    bit          rdy;
    bit          mis;
    logic [31:0] val;
  } ment_t;

  ment_t mq[$];
  int    next_tag;
  bit    e_cv, e_fl, can_alloc;
  int    k1, k2, kc;
  ment_t ne;

  function automatic int find_tag(input int tag);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].tag == tag) return i;
    return -1;
  endfunction

  // Compare outputs mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      next_tag = 0;
    end else begin
      e_cv = (mq.size() > 0) && mq[0].rdy;
      e_fl = e_cv && mq[0].mis;
      k1   = find_tag(int'(bus.lookup_tag_1));
      k2   = find_tag(int'(bus.lookup_tag_2));
      chk1("m_empty", bus.empty, mq.size() == 0);
      chk1("m_full", bus.full, mq.size() == ROBN);
      chkv("m_alloc_tag", 32'(bus.alloc_tag), 32'(next_tag));
      chk1("m_commit_valid", bus.commit_valid, e_cv);
      chk1("m_flush", bus.flush, e_fl);
      chk1("m_commit_wr", bus.commit_writes_reg, e_cv && mq[0].wr);
      if (e_cv) begin
        chkv("m_commit_dest", 32'(bus.commit_dest_reg), 32'(mq[0].dest));
        chkv("m_commit_value", bus.commit_value, mq[0].val);
      end
      if (e_fl) chkv("m_redirect", bus.redirect_pc, mq[0].val);
      chk1("m_lk_rdy1", bus.lookup_ready_1, (k1 >= 0) && mq[k1].rdy);
      chk1("m_lk_rdy2", bus.lookup_ready_2, (k2 >= 0) && mq[k2].rdy);
      if (k1 >= 0 && mq[k1].rdy) chkv("m_lk_val1", bus.lookup_value_1, mq[k1].val);
      if (k2 >= 0 && mq[k2].rdy) chkv("m_lk_val2", bus.lookup_value_2, mq[k2].val);

      if (e_fl) begin
        mq.delete();
        next_tag = 0;
      end else begin
        can_alloc = mq.size() < ROBN;
        if (bus.cdb_valid) begin
          kc = find_tag(int'(bus.cdb_rob_tag));
          if (kc >= 0 && !mq[kc].rdy) begin
            mq[kc].rdy = 1'b1;
            mq[kc].val = bus.cdb_data;
            mq[kc].mis = bus.cdb_mispredicted && mq[kc].br;
          end
        end
        if (e_cv) void'(mq.pop_front());
        if (bus.alloc_en && can_alloc) begin
          ne.tag  = next_tag;
          ne.dest = bus.alloc_dest_reg;
          ne.wr   = bus.alloc_writes_reg;
          ne.br   = bus.alloc_is_branch;
          ne.rdy  = 1'b0;
          ne.mis  = 1'b0;
          ne.val  = '0;
          mq.push_back(ne);
          next_tag = (next_tag + 1) % ROBN;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.alloc_en         = 1'b0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_mispredicted = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] d, input logic wr, input logic br);
    bus.alloc_en         = 1'b1;
    bus.alloc_dest_reg   = d;
    bus.alloc_writes_reg = wr;
    bus.alloc_is_branch  = br;
    cyc();
  endtask

  task automatic cdb(input logic [2:0] t, input logic [31:0] v, input logic m);
    bus.cdb_valid        = 1'b1;
    bus.cdb_rob_tag      = t;
    bus.cdb_data         = v;
    bus.cdb_mispredicted = m;
    cyc();
  endtask

  // Wait (bounded) for the next commit and check it, then step past it.
  task automatic wait_commit(input string nm, input logic [4:0] d, input logic [31:0] v);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.commit_valid) begin
        got = 1'b1;
        chkv({nm, "_value"}, bus.commit_value, v);
        chkv({nm, "_dest"}, 32'(bus.commit_dest_reg), 32'(d));
      end
      cyc();
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no commit within 20 cycles, expected value %0h", nm, v);
    end
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 40 && !bus.empty; i++) cyc();
    chk1(nm, bus.empty, 1'b1);
  endtask

  // Asynchronous reset from a mid-cycle point; outputs must clear without an edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk1("async_rst_empty", bus.empty, 1'b1);
    chk1("async_rst_cv", bus.commit_valid, 1'b0);
    chkv("async_rst_tag", 32'(bus.alloc_tag), 32'd0);
    cyc();
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios --------------------------------------
  initial begin
    reset                = 1'b0;
    bus.alloc_en         = 1'b0;
    bus.alloc_dest_reg   = '0;
    bus.alloc_writes_reg = 1'b0;
    bus.alloc_is_branch  = 1'b0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_rob_tag      = '0;
    bus.cdb_data         = '0;
    bus.cdb_mispredicted = 1'b0;
    bus.lookup_tag_1     = 3'd0;
    bus.lookup_tag_2     = 3'd1;
    #1 reset = 1'b1;
    #2;
    chk1("rst_empty", bus.empty, 1'b1);
    chk1("rst_full", bus.full, 1'b0);
    chkv("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    chk1("rst_commit_valid", bus.commit_valid, 1'b0);
    chk1("rst_flush", bus.flush, 1'b0);
    chk1("rst_commit_wr", bus.commit_writes_reg, 1'b0);
    chkv("rst_commit_value", bus.commit_value, 32'd0);
    chkv("rst_redirect", bus.redirect_pc, 32'd0);
    chkv("rst_lk_val1", bus.lookup_value_1, 32'd0);
    chk1("rst_lk_rdy1", bus.lookup_ready_1, 1'b0);
    cyc();
    reset = 1'b0;
    cyc();

    // Fill all 8 slots, then an ignored 9th request.
    for (int i = 0; i < 8; i++) begin
      chkv("fill_tag", 32'(bus.alloc_tag), 32'(i));
      chk1("fill_not_full", bus.full, 1'b0);
      alloc(5'(8 + i), 1'b1, 1'b0);
    end
    chk1("fill_full", bus.full, 1'b1);
    bus.alloc_en = 1'b1;
    cyc();
    chk1("ninth_full", bus.full, 1'b1);
    chkv("ninth_tag", 32'(bus.alloc_tag), 32'd0);

    // Drain three out of order, refill across the wrap.
    cdb(3'd2, 32'h300, 1'b0);
    cdb(3'd0, 32'h100, 1'b0);
    wait_commit("drain0", 5'd8, 32'h100);
    cdb(3'd1, 32'h200, 1'b0);
    wait_commit("drain1", 5'd9, 32'h200);
    wait_commit("drain2", 5'd10, 32'h300);
    chk1("drained_not_full", bus.full, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chkv("wrap_tag", 32'(bus.alloc_tag), 32'(i));
      alloc(5'(20 + i), 1'b1, 1'b0);
    end
    chk1("wrap_full", bus.full, 1'b1);
    cdb(3'd2, 32'hA02, 1'b0);
    cdb(3'd1, 32'hA01, 1'b0);
    cdb(3'd0, 32'hA00, 1'b0);
    cdb(3'd7, 32'hA07, 1'b0);
    cdb(3'd6, 32'hA06, 1'b0);
    cdb(3'd5, 32'hA05, 1'b0);
    cdb(3'd4, 32'hA04, 1'b0);
    cdb(3'd3, 32'hA03, 1'b0);
    wait_commit("wrap_c3", 5'd11, 32'hA03);
    wait_commit("wrap_c4", 5'd12, 32'hA04);
    wait_commit("wrap_c5", 5'd13, 32'hA05);
    wait_commit("wrap_c6", 5'd14, 32'hA06);
    wait_commit("wrap_c7", 5'd15, 32'hA07);
    wait_commit("wrap_c0", 5'd20, 32'hA00);
    wait_commit("wrap_c1", 5'd21, 32'hA01);
    wait_commit("wrap_c2", 5'd22, 32'hA02);
    wait_empty("wrap_empty");

    // Out-of-order completion, in-order retire, starting from tag 0.
    alloc(5'd3, 1'b1, 1'b0);
    do_reset();
    alloc(5'd5, 1'b1, 1'b0);
    alloc(5'd6, 1'b1, 1'b0);
    cdb(3'd1, 32'h22, 1'b0);
    chk1("ooo_hold", bus.commit_valid, 1'b0);
    cdb(3'd0, 32'h11, 1'b0);
    wait_commit("ooo0", 5'd5, 32'h11);
    wait_commit("ooo1", 5'd6, 32'h22);
    chk1("ooo_empty", bus.empty, 1'b1);

    // Mispredicted branch at tag 2 with younger entries behind it.
    do_reset();
    alloc(5'd3, 1'b1, 1'b0);
    alloc(5'd4, 1'b0, 1'b0);
    alloc(5'd1, 1'b1, 1'b1);
    alloc(5'd7, 1'b1, 1'b0);
    alloc(5'd8, 1'b1, 1'b1);
    alloc(5'd9, 1'b1, 1'b0);
    cdb(3'd0, 32'h50, 1'b0);
    cdb(3'd1, 32'h60, 1'b1);
    chk1("nonbr_mis_noflush", bus.flush, 1'b0);
    chk1("nowrite_commit", bus.commit_writes_reg, 1'b0);
    cdb(3'd2, 32'h100, 1'b1);
    bus.alloc_en         = 1'b1;
    bus.alloc_dest_reg   = 5'd30;
    bus.alloc_writes_reg = 1'b1;
    bus.alloc_is_branch  = 1'b0;
    bus.cdb_valid        = 1'b1;
    bus.cdb_rob_tag      = 3'd3;
    bus.cdb_data         = 32'hDEAD;
    #1;
    chk1("flush_cv", bus.commit_valid, 1'b1);
    chk1("flush", bus.flush, 1'b1);
    chkv("redirect", bus.redirect_pc, 32'h100);
    chk1("flush_link_wr", bus.commit_writes_reg, 1'b1);
    chkv("flush_dest", 32'(bus.commit_dest_reg), 32'd1);
    cyc();
    chk1("post_flush_empty", bus.empty, 1'b1);
    chkv("post_flush_tag", 32'(bus.alloc_tag), 32'd0);
    chk1("post_flush_noflush", bus.flush, 1'b0);
    cyc();
    chk1("post_flush_still_empty", bus.empty, 1'b1);

    // Operand lookup before/after writeback; stray broadcast ignored.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(1 + i), 1'b1, 1'b0);
    bus.lookup_tag_1 = 3'd4;
    bus.lookup_tag_2 = 3'd6;
    #1;
    chk1("lk_before", bus.lookup_ready_1, 1'b0);
    cdb(3'd4, 32'hABCD, 1'b0);
    chk1("lk_after", bus.lookup_ready_1, 1'b1);
    chkv("lk_value", bus.lookup_value_1, 32'hABCD);
    cdb(3'd6, 32'h5555, 1'b0);
    chk1("stray_rdy", bus.lookup_ready_2, 1'b0);
    chk1("stray_empty", bus.empty, 1'b0);
    chkv("stray_tag", 32'(bus.alloc_tag), 32'd5);
    cdb(3'd4, 32'h7777, 1'b0);
    chkv("dup_ignored", bus.lookup_value_1, 32'hABCD);
    cdb(3'd1, 32'hB1, 1'b0);
    cdb(3'd0, 32'hB0, 1'b0);
    cdb(3'd3, 32'hB3, 1'b0);
    cdb(3'd2, 32'hB2, 1'b0);
    wait_empty("lk_drain_empty");

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order reorder buffer that sits directly downstream of the common data bus (CDB) driven by functional-unit output buffers, such as the branch unit's. It allocates a tag per dispatched instruction and captures results broadcast on the CDB. It retires entries in program order to the register file. A mispredicted branch reaching the head triggers a full pipeline flush and a redirect to the corrected PC.

## Interface
Parameters:
- XLEN, 32, datapath width
- ROB_SIZE, 8, entry count; power of two, at least 2
- TAG_WIDTH, $clog2(ROB_SIZE), tag width; tag = entry index

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- alloc_en  input  1  dispatch requests an entry this cycle
- alloc_dest_reg  input  5  destination architectural register
- alloc_writes_reg  input  1  entry writes the register file on commit
- alloc_is_branch  input  1  entry is a branch/jump; its CDB value is the resolved next PC
- alloc_tag  output  TAG_WIDTH  tag granted (= tail index); valid while !full
- full  output  1  no free entry
- empty  output  1  no occupied entry
- cdb_valid  input  1  CDB carries a result this cycle
- cdb_rob_tag  input  TAG_WIDTH  tag of broadcast result
- cdb_data  input  XLEN  broadcast result
- cdb_mispredicted  input  1  the broadcasting branch was mispredicted
- lookup_tag_1, lookup_tag_2  input  TAG_WIDTH  operand tags queried at dispatch
- lookup_ready_1, lookup_ready_2  output  1  queried entry is busy and has its result
- lookup_value_1, lookup_value_2  output  XLEN  stored result of queried entry
- commit_valid  output  1  head entry retires this cycle
- commit_dest_reg  output  5  head destination register
- commit_value  output  XLEN  head result
- commit_writes_reg  output  1  commit_valid && head writes the register file
- flush  output  1  head is a mispredicted branch retiring now
- redirect_pc  output  XLEN  corrected fetch address; equals commit_value when flush

## Operation
- State:
  - Per entry: busy, ready, is_branch, mispredicted, writes_reg, dest_reg, value.
  - Pointers: head and tail, each TAG_WIDTH+1 bits; the MSB is the wrap bit.
- Status flags:
  - empty: head == tail.
  - full: index bits equal and wrap bits differ.
- Allocate: when alloc_en && !full && !flush, write the entry at the tail (busy=1, ready=0), then tail+1. When alloc_en is asserted while full, the request is ignored with no state change. Dispatch must stall on full.
- Writeback: when cdb_valid, the entry at cdb_rob_tag is busy and not yet ready:
  - set ready=1;
  - value=cdb_data;
  - mispredicted=cdb_mispredicted && is_branch.
  - A broadcast to a non-busy or already-ready entry is ignored.
- Commit: commit_valid = head busy && ready; combinational from registers. On commit, clear head busy and advance head by 1. At most one commit per cycle.
- Flush: flush = commit_valid && head mispredicted. On the next edge, all entries clear busy/ready and head = tail = 0. Allocation and CDB writes in the flush cycle are discarded. The flushing branch itself still reports commit_valid; commit_writes_reg follows its writes_reg bit, so JAL/JALR link writes proceed.
- Lookup: purely combinational from stored state. There is no CDB bypass; the reservation station snoops the CDB itself.
- Pointer arithmetic is modulo 2·ROB_SIZE, so wrap-around is natural overflow.

## Timing
- Reset values:
  - all entries: busy=0, ready=0;
  - head = tail = 0;
  - empty=1, full=0, alloc_tag=0;
  - commit_valid=0, flush=0, commit_writes_reg=0;
  - commit_value, redirect_pc, lookup_value_* = 0.
- Allocation at edge N gives busy at N+1.
- A CDB write at edge N gives ready at N+1; the earliest commit_valid is cycle N+1, i.e. a one-cycle CDB-to-commit latency.
- Allocate and commit in the same cycle are both performed. When full, the freed slot is usable only from the next cycle; full has no same-cycle bypass.
- A CDB write and a commit of different entries in the same cycle are both performed.
- Reset asserted mid-operation clears state immediately (asynchronous); outputs take their reset values without waiting for a clock edge.

## Structure
- Shared package: rob_entry struct (busy, ready, is_branch, mispredicted, writes_reg, dest_reg[4:0], value[XLEN-1:0]).
- No sub-module: pointer logic and the entry array sit inline in reorder_buffer.

## Test plan
- Reset, then no stimulus → empty=1, full=0, alloc_tag=0, commit_valid=0, flush=0.
- Allocate 8 entries (ROB_SIZE=8) → alloc_tag 0..7, full=1 after the 8th; a 9th alloc_en is ignored and tail is unchanged.
- Allocate tags 0,1; CDB writes tag 1 first (value 0x22), then tag 0 (0x11) → commits appear in order: 0x11 to tag 0's reg, then 0x22; empty=1 afterwards.
- Fill, drain 3, allocate 3 more → alloc_tag wraps to 0,1,2; full returns to 1; in-order commit continues correctly across the wrap.
- Branch at tag 2 with cdb_mispredicted=1, cdb_data=0x100, tags 3–5 busy → on its commit cycle flush=1 and redirect_pc=0x100; the next cycle empty=1 and alloc_tag=0.
- Lookup tag 4 before and after a CDB write of 0xABCD → lookup_ready goes 0, then 1 with value 0xABCD; a CDB write to an unallocated tag changes nothing.
